mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of cycles m_req is held without m_ready before the transaction is aborted.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_req  input  1  instruction-fetch read request; held until i_gnt.
REQ-005 i_addr  input  32  instruction byte address.
REQ-006 i_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-007 i_valid  output  1  one-cycle pulse: i_rdata valid.
REQ-008 i_rdata  output  32  fetched instruction word.
REQ-009 d_req  input  1  data request; held until d_gnt.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_gnt  output  1  one-cycle pulse: data request accepted.
REQ-014 d_valid  output  1  one-cycle pulse: load data valid or store complete.
REQ-015 d_rdata  output  32  load data (0 for stores).
REQ-016 m_req  output  1  memory access active; held until m_ready or timeout.
REQ-017 m_we  output  1  memory write enable.
REQ-018 m_addr  output  32  memory byte address.
REQ-019 m_wdata  output  32  memory write data.
REQ-020 m_rdata  input  32  memory read data, sampled when m_ready=1.
REQ-021 m_ready  input  1  memory completion strobe.
REQ-022 err  output  1  one-cycle pulse: misaligned address or timeout.

Function
REQ-023 Controller states SHALL be IDLE, I_BUSY, D_BUSY; only IDLE arbitrates.
REQ-024 In IDLE with exactly one request, that requester SHALL be granted (gnt pulse) in the same cycle.
REQ-025 In IDLE with both requests, grant SHALL go to the requester not served last (round-robin flag); reset value of flag = instruction, so data wins the first tie.
REQ-026 On grant, addr/we/wdata SHALL be registered; from the next cycle m_req=1 with registered m_addr/m_we/m_wdata (i-side: m_we=0, m_wdata=0), stable until completion.
REQ-027 Completion: cycle with m_req=1 and m_ready=1; next cycle the owner's valid SHALL pulse with rdata = captured m_rdata (d_rdata=0 for stores), state returns to IDLE.
REQ-028 Minimum latency: gnt at cycle T, m_ready at T+1 -> valid at T+2; next grant no earlier than T+2.
REQ-029 Address with addr[1:0]!=0 SHALL be granted, issue no memory access, and produce valid and err together the next cycle with rdata=0.
REQ-030 i_addr==0 SHALL be granted, issue no memory access, and return i_valid next cycle with i_rdata=0 (nop), err=0.
REQ-031 Cycle counter SHALL count m_req cycles; when TIMEOUT cycles elapse without m_ready, m_req drops, owner valid pulses with rdata=0, err pulses, state IDLE.
REQ-032 m_ready while m_req=0 SHALL be ignored.
REQ-033 A request dropped before grant SHALL cause no transaction; requests arriving while busy wait, no gnt.
REQ-034 gnt, valid, err SHALL never be high for more than one cycle per transaction; i_gnt and d_gnt never simultaneously high.

Reset
REQ-035 Reset SHALL force state IDLE, round-robin flag=instruction, counter=0, and all outputs 0 on the next edge.
REQ-036 Reset mid-transaction SHALL abort it: m_req=0 next cycle, no valid or err pulse for the aborted request.

Verification
REQ-037 i_req, i_addr=0x00400000, m_ready one cycle after m_req, m_rdata=0x20080005 -> i_gnt at T, i_valid at T+2, i_rdata=0x20080005.
REQ-038 i_req and d_req (load 0x10010000) same cycle from reset -> d_gnt first; i_gnt at IDLE after d_valid; next tie grants instruction.
REQ-039 d_req store, d_addr=0x10010004, d_wdata=0xCAFEF00D -> m_we=1, m_addr/m_wdata match until m_ready; d_valid with d_rdata=0.
REQ-040 d_addr=0x10010002 -> d_gnt, no m_req, d_valid+err next cycle, d_rdata=0.
REQ-041 i_req with m_ready never asserted, TIMEOUT=16 -> m_req high exactly 16 cycles, then i_valid+err, i_rdata=0.
REQ-042 reset asserted two cycles into a D_BUSY access -> m_req=0 next cycle, no d_valid, fresh request granted normally afterward.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
// Bus bundle for mem_port_arbiter: fetch port, data port, memory port and error strobe.
// slave = arbiter's view; master = the surrounding CPU/memory environment.
interface mem_port_arbiter_if;
    // Handshake: a requester raises *_req with stable address/data and holds it until
    // the matching *_gnt pulse; the result comes back later as a one-cycle *_valid.
    // The memory sees m_req held with stable m_addr/m_we/m_wdata until the cycle
    // m_ready=1 (data on m_rdata that same cycle) or until the arbiter times out.
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_valid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        output i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
               m_req, m_we, m_addr, m_wdata, err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ready,
        input  i_gnt, i_valid, i_rdata, d_gnt, d_valid, d_rdata,
               m_req, m_we, m_addr, m_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// Arbitrates an instruction-fetch port and a data port onto one memory port,
// with round-robin tie-break, misaligned/nop short paths and an access timeout.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus,
    output logic [1:0]        state_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_d_q, last_d_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          i_valid_q, i_valid_d;
    logic          d_valid_q, d_valid_d;
    logic          err_q, err_d;
    logic [31:0]   i_rdata_q, i_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          pick_i, pick_d;
    logic          expired;

    assign expired = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d_d  = last_d_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        i_valid_d = 1'b0;
        d_valid_d = 1'b0;
        err_d     = 1'b0;
        i_rdata_d = 32'd0;
        d_rdata_d = 32'd0;
        pick_i    = 1'b0;
        pick_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Grants are suppressed while reset is asserted so nothing is accepted and lost.
                if (!reset) begin
                    pick_d = bus.d_req && (!bus.i_req || !last_d_q);
                    pick_i = bus.i_req && !pick_d;
                end
                if (pick_d) begin
                    last_d_d = 1'b1;
                    if (bus.d_addr[1:0] != 2'b00) begin
                        d_valid_d = 1'b1;
                        err_d     = 1'b1;
                    end else begin
                        state_d = D_BUSY;
                        addr_d  = bus.d_addr;
                        we_d    = bus.d_we;
                        wdata_d = bus.d_wdata;
                        cnt_d   = '0;
                    end
                end else if (pick_i) begin
                    last_d_d = 1'b0;
                    if (bus.i_addr[1:0] != 2'b00) begin
                        i_valid_d = 1'b1;
                        err_d     = 1'b1;
                    end else if (bus.i_addr == 32'd0) begin
                        i_valid_d = 1'b1;
                    end else begin
                        state_d = I_BUSY;
                        addr_d  = bus.i_addr;
                        we_d    = 1'b0;
                        wdata_d = 32'd0;
                        cnt_d   = '0;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                // Completion wins over timeout when m_ready lands on the last allowed cycle.
                if (bus.m_ready) begin
                    state_d = IDLE;
                    if (state_q == I_BUSY) begin
                        i_valid_d = 1'b1;
                        i_rdata_d = bus.m_rdata;
                    end else begin
                        d_valid_d = 1'b1;
                        d_rdata_d = we_q ? 32'd0 : bus.m_rdata;
                    end
                end else if (expired) begin
                    state_d   = IDLE;
                    err_d     = 1'b1;
                    i_valid_d = (state_q == I_BUSY);
                    d_valid_d = (state_q == D_BUSY);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_d_q  <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            we_q      <= 1'b0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            err_q     <= 1'b0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_d_q  <= last_d_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
            err_q     <= err_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus.i_gnt   = pick_i;
    assign bus.d_gnt   = pick_d;
    assign bus.i_valid = i_valid_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_valid = d_valid_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.err     = err_q;
    assign bus.m_req   = (state_q != IDLE);
    assign bus.m_we    = we_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = wdata_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// Bench for mem_port_arbiter: directed scenarios plus a randomized stream of single
// transactions checked against a transaction-level model and an expected-data queue.
module tb_mem_port_arbiter;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  state_o;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    // ---------------- clock / reset / driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.i_req   = 1'b0;
        bus.i_addr  = 32'd0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'd0;
        bus.d_wdata = 32'd0;
        bus.m_rdata = 32'd0;
        bus.m_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // Outcome of one isolated request given the memory's response latency
    // (lat = number of m_req cycles before m_ready is raised).
    function automatic void model(input bit is_d, input bit we, input logic [31:0] addr,
                                  input int lat, input logic [31:0] mdata,
                                  output int mcyc, output bit e, output logic [31:0] rd);
        bit misaligned = (addr % 4) != 0;
        bit nop        = !is_d && (addr == 32'd0);
        if (misaligned || nop) begin
            mcyc = 0;
            e    = misaligned;
            rd   = 32'd0;
        end else if (lat < TIMEOUT) begin
            mcyc = lat + 1;
            e    = 1'b0;
            rd   = (is_d && we) ? 32'd0 : mdata;
        end else begin
            mcyc = TIMEOUT;
            e    = 1'b1;
            rd   = 32'd0;
        end
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        smp();
        checks++; if ({bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid, bus.err} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 00000", {bus.i_gnt, bus.d_gnt, bus.i_valid, bus.d_valid, bus.err}); end
        checks++; if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata} !== 66'd0) begin errors++; $display("FAIL reset_mem: m_req=%b m_we=%b m_addr=%h m_wdata=%h want all 0", bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata); end
        checks++; if ({bus.i_rdata, bus.d_rdata} !== 64'd0) begin errors++; $display("FAIL reset_rdata: i=%h d=%h want 0", bus.i_rdata, bus.d_rdata); end
        checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
    endtask

    task automatic test_fetch();
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h0040_0000;
        smp();
        checks++; if ({bus.i_gnt, bus.d_gnt} !== 2'b10) begin errors++; $display("FAIL fetch_gnt: got %b want 10", {bus.i_gnt, bus.d_gnt}); end
        cyc(); bus.i_req = 1'b0; bus.m_ready = 1'b1; bus.m_rdata = 32'h2008_0005;
        smp();
        checks++; if ({bus.m_req, bus.m_we, bus.i_valid} !== 3'b100) begin errors++; $display("FAIL fetch_mreq: got %b want 100", {bus.m_req, bus.m_we, bus.i_valid}); end
        checks++; if ({bus.m_addr, bus.m_wdata} !== {32'h0040_0000, 32'd0}) begin errors++; $display("FAIL fetch_maddr: addr=%h wdata=%h", bus.m_addr, bus.m_wdata); end
        cyc(); bus.m_ready = 1'b0; bus.m_rdata = 32'd0;
        smp();
        checks++; if ({bus.i_valid, bus.err, bus.m_req} !== 3'b100) begin errors++; $display("FAIL fetch_valid: got %b want 100", {bus.i_valid, bus.err, bus.m_req}); end
        checks++; if (bus.i_rdata !== 32'h2008_0005) begin errors++; $display("FAIL fetch_rdata: got %h want 20080005", bus.i_rdata); end
        cyc(); smp();
        checks++; if (bus.i_valid !== 1'b0) begin errors++; $display("FAIL fetch_pulse: i_valid=%b want 0", bus.i_valid); end
    endtask

    task automatic test_tie();
        do_reset();
        bus.i_req = 1'b1; bus.i_addr = 32'h0040_0010;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0000;
        smp();
        checks++; if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin errors++; $display("FAIL tie1_gnt: got %b want 01", {bus.i_gnt, bus.d_gnt}); end
        cyc(); bus.d_addr = 32'h1001_0008; bus.m_ready = 1'b1; bus.m_rdata = 32'hAAAA_0001;
        smp();
        checks++; if ({bus.m_req, bus.i_gnt, bus.d_gnt} !== 3'b100) begin errors++; $display("FAIL tie_busy_nogrant: got %b want 100", {bus.m_req, bus.i_gnt, bus.d_gnt}); end
        checks++; if (bus.m_addr !== 32'h1001_0000) begin errors++; $display("FAIL tie1_maddr: got %h want 10010000", bus.m_addr); end
        cyc(); bus.m_ready = 1'b0;
        smp();
        checks++; if ({bus.d_valid, bus.d_rdata} !== {1'b1, 32'hAAAA_0001}) begin errors++; $display("FAIL tie1_dvalid: valid=%b rdata=%h want 1 aaaa0001", bus.d_valid, bus.d_rdata); end
        checks++; if ({bus.i_gnt, bus.d_gnt} !== 2'b10) begin errors++; $display("FAIL tie2_gnt: got %b want 10", {bus.i_gnt, bus.d_gnt}); end
        cyc(); bus.i_req = 1'b0; bus.m_ready = 1'b1; bus.m_rdata = 32'hBBBB_0002;
        smp();
        checks++; if ({bus.m_addr, bus.d_gnt} !== {32'h0040_0010, 1'b0}) begin errors++; $display("FAIL tie2_maddr: addr=%h d_gnt=%b", bus.m_addr, bus.d_gnt); end
        cyc(); bus.m_ready = 1'b0;
        smp();
        checks++; if ({bus.i_valid, bus.i_rdata} !== {1'b1, 32'hBBBB_0002}) begin errors++; $display("FAIL tie2_ivalid: valid=%b rdata=%h want 1 bbbb0002", bus.i_valid, bus.i_rdata); end
        checks++; if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin errors++; $display("FAIL tie3_gnt: got %b want 01", {bus.i_gnt, bus.d_gnt}); end
        cyc(); bus.d_req = 1'b0; bus.m_ready = 1'b1; bus.m_rdata = 32'hCCCC_0003;
        smp();
        checks++; if (bus.m_addr !== 32'h1001_0008) begin errors++; $display("FAIL tie3_maddr: got %h want 10010008", bus.m_addr); end
        cyc(); bus.m_ready = 1'b0;
        smp();
        checks++; if ({bus.d_valid, bus.d_rdata} !== {1'b1, 32'hCCCC_0003}) begin errors++; $display("FAIL tie3_dvalid: valid=%b rdata=%h", bus.d_valid, bus.d_rdata); end
    endtask

    task automatic test_store();
        do_reset();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1001_0004; bus.d_wdata = 32'hCAFE_F00D;
        smp();
        checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL store_gnt: got %b want 1", bus.d_gnt); end
        cyc(); bus.d_req = 1'b0; bus.d_wdata = 32'd0;
        for (int k = 0; k < 3; k++) begin
            bus.m_ready = (k == 2); bus.m_rdata = 32'h1234_5678;
            smp();
            checks++; if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.d_valid} !== {2'b11, 32'h1001_0004, 32'hCAFE_F00D, 1'b0}) begin errors++; $display("FAIL store_mbus: cycle %0d req=%b we=%b addr=%h wdata=%h dv=%b", k, bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.d_valid); end
            cyc();
        end
        bus.m_ready = 1'b0;
        smp();
        checks++; if ({bus.d_valid, bus.err, bus.d_rdata} !== {2'b10, 32'd0}) begin errors++; $display("FAIL store_done: valid=%b err=%b rdata=%h want 1 0 0", bus.d_valid, bus.err, bus.d_rdata); end
    endtask

    task automatic test_short_paths();
        do_reset();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0002;
        smp();
        checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL misal_d_gnt: got %b want 1", bus.d_gnt); end
        cyc(); bus.d_req = 1'b0; bus.m_rdata = 32'hFFFF_FFFF;
        smp();
        checks++; if ({bus.m_req, bus.d_valid, bus.err, bus.d_rdata} !== {3'b011, 32'd0}) begin errors++; $display("FAIL misal_d_resp: mreq=%b valid=%b err=%b rdata=%h", bus.m_req, bus.d_valid, bus.err, bus.d_rdata); end
        cyc(); bus.i_req = 1'b1; bus.i_addr = 32'h0040_0003;
        smp();
        checks++; if (bus.i_gnt !== 1'b1) begin errors++; $display("FAIL misal_i_gnt: got %b want 1", bus.i_gnt); end
        cyc(); bus.i_req = 1'b0;
        smp();
        checks++; if ({bus.m_req, bus.i_valid, bus.err, bus.i_rdata} !== {3'b011, 32'd0}) begin errors++; $display("FAIL misal_i_resp: mreq=%b valid=%b err=%b rdata=%h", bus.m_req, bus.i_valid, bus.err, bus.i_rdata); end
        cyc(); bus.i_req = 1'b1; bus.i_addr = 32'd0;
        smp();
        checks++; if (bus.i_gnt !== 1'b1) begin errors++; $display("FAIL nop_gnt: got %b want 1", bus.i_gnt); end
        cyc(); bus.i_req = 1'b0;
        smp();
        checks++; if ({bus.m_req, bus.i_valid, bus.err, bus.i_rdata} !== {3'b010, 32'd0}) begin errors++; $display("FAIL nop_resp: mreq=%b valid=%b err=%b rdata=%h", bus.m_req, bus.i_valid, bus.err, bus.i_rdata); end
        cyc(); bus.m_rdata = 32'd0;
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        bus.m_ready = 1'b1; bus.m_rdata = 32'h5555_5555;
        cyc(); bus.m_ready = 1'b0;
        smp();
        checks++; if ({bus.m_req, bus.i_valid, bus.d_valid, bus.err} !== 4'b0) begin errors++; $display("FAIL idle_ready_ignored: got %b want 0000", {bus.m_req, bus.i_valid, bus.d_valid, bus.err}); end
        cyc(); bus.i_req = 1'b1; bus.i_addr = 32'h0040_0020;
        smp();
        checks++; if (bus.i_gnt !== 1'b1) begin errors++; $display("FAIL tmo_gnt: got %b want 1", bus.i_gnt); end
        cyc(); bus.i_req = 1'b0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            smp();
            if (!bus.m_req) break;
            n++;
            cyc();
        end
        checks++; if (n !== TIMEOUT) begin errors++; $display("FAIL tmo_mreq_cycles: got %0d want %0d", n, TIMEOUT); end
        checks++; if ({bus.i_valid, bus.err, bus.i_rdata} !== {2'b11, 32'd0}) begin errors++; $display("FAIL tmo_resp: valid=%b err=%b rdata=%h want 1 1 0", bus.i_valid, bus.err, bus.i_rdata); end
        cyc(); smp();
        checks++; if ({bus.i_valid, bus.err} !== 2'b00) begin errors++; $display("FAIL tmo_pulse: got %b want 00", {bus.i_valid, bus.err}); end
        cyc(); bus.m_rdata = 32'd0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0010;
        smp();
        checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt: got %b want 1", bus.d_gnt); end
        cyc(); bus.d_req = 1'b0;
        cyc(); reset = 1'b1; bus.m_ready = 1'b1; bus.m_rdata = 32'h7777_7777;
        smp();
        checks++; if (bus.m_req !== 1'b1) begin errors++; $display("FAIL rmid_busy: m_req=%b want 1", bus.m_req); end
        cyc(); reset = 1'b0; bus.m_ready = 1'b0;
        smp();
        checks++; if ({bus.m_req, bus.d_valid, bus.err} !== 3'b000) begin errors++; $display("FAIL rmid_abort: got %b want 000", {bus.m_req, bus.d_valid, bus.err}); end
        cyc(); smp();
        checks++; if ({bus.d_valid, bus.err} !== 2'b00) begin errors++; $display("FAIL rmid_no_late_valid: got %b want 00", {bus.d_valid, bus.err}); end
        cyc(); bus.d_req = 1'b1; bus.d_addr = 32'h1001_0014;
        smp();
        checks++; if (bus.d_gnt !== 1'b1) begin errors++; $display("FAIL rmid_fresh_gnt: got %b want 1", bus.d_gnt); end
        cyc(); bus.d_req = 1'b0; bus.m_ready = 1'b1; bus.m_rdata = 32'h0BAD_BEEF;
        smp();
        checks++; if ({bus.m_req, bus.m_addr} !== {1'b1, 32'h1001_0014}) begin errors++; $display("FAIL rmid_fresh_maddr: req=%b addr=%h", bus.m_req, bus.m_addr); end
        cyc(); bus.m_ready = 1'b0;
        smp();
        checks++; if ({bus.d_valid, bus.d_rdata} !== {1'b1, 32'h0BAD_BEEF}) begin errors++; $display("FAIL rmid_fresh_resp: valid=%b rdata=%h", bus.d_valid, bus.d_rdata); end
    endtask

    task automatic test_drop();
        do_reset();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0018;
        cyc(); bus.d_req = 1'b0; bus.i_req = 1'b1; bus.i_addr = 32'h0040_0030;
        smp();
        checks++; if (bus.i_gnt !== 1'b0) begin errors++; $display("FAIL drop_busy_gnt: got %b want 0", bus.i_gnt); end
        cyc(); bus.i_req = 1'b0; bus.m_ready = 1'b1; bus.m_rdata = 32'h4444_0004;
        smp();
        checks++; if (bus.i_gnt !== 1'b0) begin errors++; $display("FAIL drop_gnt2: got %b want 0", bus.i_gnt); end
        cyc(); bus.m_ready = 1'b0;
        smp();
        checks++; if ({bus.d_valid, bus.i_gnt} !== 2'b10) begin errors++; $display("FAIL drop_dvalid: got %b want 10", {bus.d_valid, bus.i_gnt}); end
        cyc(); smp();
        checks++; if ({bus.m_req, bus.i_gnt, bus.i_valid} !== 3'b000) begin errors++; $display("FAIL drop_no_txn: got %b want 000", {bus.m_req, bus.i_gnt, bus.i_valid}); end
    endtask

    task automatic test_random();
        bit          is_d, we, e;
        int          lat, mcyc, sel;
        logic [31:0] addr, wdata, mdata, rd, exp;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            is_d  = 1'($urandom_range(0, 1));
            we    = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            sel   = int'($urandom_range(0, 9));
            addr  = $urandom;
            if (sel < 7) addr[1:0] = 2'b00;
            else if (sel == 7) addr = 32'd0;
            else addr[1:0] = 2'($urandom_range(1, 3));
            wdata = $urandom;
            mdata = $urandom;
            lat   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 1)) : int'($urandom_range(0, 4));
            model(is_d, we, addr, lat, mdata, mcyc, e, rd);
            exp_q.push_back(rd);
            if (is_d) begin
                bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
            end else begin
                bus.i_req = 1'b1; bus.i_addr = addr;
            end
            smp();
            checks++; if ({bus.i_gnt, bus.d_gnt} !== {!is_d, is_d}) begin errors++; $display("FAIL rnd_gnt: txn %0d got %b want %b", n, {bus.i_gnt, bus.d_gnt}, {!is_d, is_d}); end
            cyc(); bus.i_req = 1'b0; bus.d_req = 1'b0;
            for (int k = 0; k < mcyc; k++) begin
                bus.m_ready = (k == lat);
                bus.m_rdata = (k == lat) ? mdata : $urandom;
                smp();
                checks++; if ({bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.i_valid, bus.d_valid} !== {1'b1, we, addr, (is_d ? wdata : 32'd0), 2'b00}) begin errors++; $display("FAIL rnd_mbus: txn %0d cyc %0d req=%b we=%b addr=%h wdata=%h iv=%b dv=%b want addr=%h", n, k, bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata, bus.i_valid, bus.d_valid, addr); end
                cyc();
            end
            bus.m_ready = 1'b0;
            bus.m_rdata = $urandom;
            smp();
            exp = exp_q.pop_front();
            checks++; if ({bus.m_req, bus.i_valid, bus.d_valid, bus.err} !== {1'b0, !is_d, is_d, e}) begin errors++; $display("FAIL rnd_resp: txn %0d got req/iv/dv/err=%b want %b", n, {bus.m_req, bus.i_valid, bus.d_valid, bus.err}, {1'b0, !is_d, is_d, e}); end
            checks++; if ((is_d ? bus.d_rdata : bus.i_rdata) !== exp) begin errors++; $display("FAIL rnd_rdata: txn %0d got %h want %h", n, (is_d ? bus.d_rdata : bus.i_rdata), exp); end
            cyc();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_tie();
        test_store();
        test_short_paths();
        test_timeout();
        test_reset_mid();
        test_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
